// File: rtl/tetris_key_pkg.sv
// Shared encodings for the keyboard-to-game-command path: command codes,
// scan codes, repeat FSM states and the output priority picker.
package tetris_key_pkg;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    LEFT      = 3'd1,
    RIGHT     = 3'd2,
    SOFT_DROP = 3'd3,
    ROTATE    = 3'd4,
    HARD_DROP = 3'd5,
    HOLD      = 3'd6
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

  localparam logic [8:0] KEY_HARD_DROP = 9'h029;
  localparam logic [8:0] KEY_HOLD      = 9'h021;
  localparam logic [8:0] KEY_ROTATE    = 9'h175;
  localparam logic [8:0] KEY_LEFT      = 9'h16B;
  localparam logic [8:0] KEY_RIGHT     = 9'h174;
  localparam logic [8:0] KEY_SOFT_DROP = 9'h172;

  // Entry i holds the scan code of command i+1; the repeatable keys sit in 0..2.
  localparam logic [5:0][8:0] KEY_CODE =
    {KEY_HOLD, KEY_HARD_DROP, KEY_ROTATE, KEY_SOFT_DROP, KEY_RIGHT, KEY_LEFT};

  function automatic logic [5:0] cmd_bit(cmd_t c);
    return (c == NONE) ? 6'd0 : (6'd1 << (3'(c) - 3'd1));
  endfunction

  function automatic cmd_t pick_cmd(logic [5:0] p);
    if      (|(p & cmd_bit(HARD_DROP))) return HARD_DROP;
    else if (|(p & cmd_bit(HOLD)))      return HOLD;
    else if (|(p & cmd_bit(ROTATE)))    return ROTATE;
    else if (|(p & cmd_bit(LEFT)))      return LEFT;
    else if (|(p & cmd_bit(RIGHT)))     return RIGHT;
    else if (|(p & cmd_bit(SOFT_DROP))) return SOFT_DROP;
    else                                return NONE;
  endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Delayed auto-shift / auto-repeat timer for one held key. fire is a decode of
// the registered state so the top can fold it into the same edge as a press.
module key_repeat_timer
  import tetris_key_pkg::*;
#(
  parameter int DAS_CYCLES = 16000000,
  parameter int ARR_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic press,
  input  logic held,
  output logic fire
);

  rpt_state_t  state;
  logic [31:0] cnt;

  assign fire = held && (state != IDLE) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!held) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (press) begin
          state <= DELAY;
          cnt   <= 32'(DAS_CYCLES - 1);
        end
        // Typematic re-presses are ignored here so the cadence is not restarted.
        DELAY, REPEAT: if (cnt == '0) begin
          state <= REPEAT;
          cnt   <= 32'(ARR_CYCLES - 1);
        end else begin
          cnt <= cnt - 32'd1;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_cmd_gen.sv
// Turns keyboard press events into prioritised game commands with a
// valid/ready output. Auto-repeat for LEFT/RIGHT/SOFT_DROP: KEYCMD_AUTOREPEAT_EN.
module key_cmd_gen
  import tetris_key_pkg::*;
#(
  parameter int DAS_CYCLES = 16000000,
  parameter int ARR_CYCLES = 5000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [511:0] key_down,
  input  logic [8:0]   last_change,
  input  logic         key_valid,
  output logic         cmd_valid,
  output cmd_t         cmd,
  input  logic         cmd_ready
);

  logic [5:0] press, fire, set, clr, pending;
  logic       load;
  cmd_t       nxt;
  logic       unused_keys;

  assign unused_keys = ^key_down;

  for (genvar i = 0; i < 6; i++) begin : g_press
    assign press[i] = key_valid && (last_change == KEY_CODE[i]) && key_down[KEY_CODE[i]];
  end

`ifdef KEYCMD_AUTOREPEAT_EN
  for (genvar i = 0; i < 3; i++) begin : g_rpt
    key_repeat_timer #(
      .DAS_CYCLES (DAS_CYCLES),
      .ARR_CYCLES (ARR_CYCLES)
    ) u_rpt (
      .clk   (clk),
      .rst_n (rst_n),
      .press (press[i]),
      .held  (key_down[KEY_CODE[i]]),
      .fire  (fire[i])
    );
  end
  assign fire[5:3] = '0;
`else
  logic unused_cfg;
  assign unused_cfg = ^{DAS_CYCLES, ARR_CYCLES};
  assign fire       = '0;
`endif

  assign set  = press | fire;
  assign load = !cmd_valid || cmd_ready;
  assign nxt  = pick_cmd(pending);
  assign clr  = load ? cmd_bit(nxt) : 6'd0;

  // Clear-then-set ordering lets a same-cycle set survive the load that consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      cmd_valid <= 1'b0;
      cmd       <= NONE;
    end else begin
      pending <= (pending & ~clr) | set;
      if (load) begin
        cmd_valid <= (nxt != NONE);
        cmd       <= nxt;
      end
    end
  end

endmodule

// File: tb/tb_key_cmd_gen.sv
// Directed bench for key_cmd_gen; expectations follow KEYCMD_AUTOREPEAT_EN.
module tb_key_cmd_gen;
  import tetris_key_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [511:0] key_down = '0;
  logic [8:0]   last_change = '0;
  logic         key_valid = 1'b0;
  logic         cmd_ready = 1'b1;
  logic         cmd_valid;
  cmd_t         cmd;

  int cyc = 0, errors = 0, checks = 0, t0 = 0, r = 0;
  int log_cyc[$], log_cmd[$], exp_off[$], exp_cmd[$];

  key_cmd_gen #(.DAS_CYCLES(4), .ARR_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_down    (key_down),
    .last_change (last_change),
    .key_valid   (key_valid),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .cmd_ready   (cmd_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every accepted command, stamped with the cycle it was accepted in.
  always @(negedge clk)
    if (rst_n && cmd_valid && cmd_ready) begin
      log_cyc.push_back(cyc);
      log_cmd.push_back(int'(cmd));
    end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [8:0] code);
    key_down[code] = 1'b1;
    last_change    = code;
    key_valid      = 1'b1;
    t0             = cyc;
    step(1);
    key_valid      = 1'b0;
  endtask

  task automatic pulse(input logic [8:0] code);
    last_change = code;
    key_valid   = 1'b1;
    step(1);
    key_valid   = 1'b0;
  endtask

  task automatic fill_cmd(input cmd_t c);
    exp_cmd.delete();
    for (int i = 0; i < exp_off.size(); i++) exp_cmd.push_back(int'(c));
  endtask

  task automatic expect_log(input string tag, input int base);
    chk({tag, " count"}, log_cyc.size(), exp_off.size());
    for (int i = 0; i < exp_off.size(); i++)
      if (i < log_cyc.size()) begin
        chk($sformatf("%s[%0d] cycle", tag, i), log_cyc[i] - base, exp_off[i]);
        chk($sformatf("%s[%0d] cmd", tag, i), log_cmd[i], exp_cmd[i]);
      end
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_cmd.delete();
  endtask

  initial begin
    step(2);
    chk("reset valid", cmd_valid, 0);
    chk("reset cmd", cmd, int'(NONE));
    rst_n = 1'b1;
    step(2);

    // Single space press: one HARD_DROP at press+2.
    clear_log();
    press(KEY_HARD_DROP);
    key_down[KEY_HARD_DROP] = 1'b0;
    step(8);
    exp_off = {2};
    fill_cmd(HARD_DROP);
    expect_log("space", t0);

    // Left held 12 cycles.
    clear_log();
    press(KEY_LEFT);
    step(11);
    key_down[KEY_LEFT] = 1'b0;
    step(10);
`ifdef KEYCMD_AUTOREPEAT_EN
    exp_off = {2, 6, 8, 10, 12};
`else
    exp_off = {2};
`endif
    fill_cmd(LEFT);
    expect_log("left hold", t0);

    // Typematic re-press at +3 must not restart the repeat counter.
    clear_log();
    press(KEY_LEFT);
    step(2);
    pulse(KEY_LEFT);
    step(3);
    key_down[KEY_LEFT] = 1'b0;
    step(8);
`ifdef KEYCMD_AUTOREPEAT_EN
    exp_off = {2, 5, 6, 8};
`else
    exp_off = {2, 5};
`endif
    fill_cmd(LEFT);
    expect_log("typematic", t0);

    // Backpressure with three keys, then drain in priority order.
    clear_log();
    cmd_ready = 1'b0;
    press(KEY_HARD_DROP);
    press(KEY_ROTATE);
    press(KEY_HOLD);
    key_down[KEY_HARD_DROP] = 1'b0;
    key_down[KEY_ROTATE]    = 1'b0;
    key_down[KEY_HOLD]      = 1'b0;
    step(5);
    chk("stall valid", cmd_valid, 1);
    chk("stall cmd", cmd, int'(HARD_DROP));
    r = cyc;
    cmd_ready = 1'b1;
    step(6);
    exp_off = {0, 1, 2};
    exp_cmd = {int'(HARD_DROP), int'(HOLD), int'(ROTATE)};
    expect_log("drain", r);

    // Down held under backpressure: repeats coalesce into one pending flag.
    clear_log();
    cmd_ready = 1'b0;
    press(KEY_SOFT_DROP);
    step(19);
    key_down[KEY_SOFT_DROP] = 1'b0;
    r = cyc;
    cmd_ready = 1'b1;
    step(8);
`ifdef KEYCMD_AUTOREPEAT_EN
    exp_off = {0, 1};
`else
    exp_off = {0};
`endif
    fill_cmd(SOFT_DROP);
    expect_log("coalesce", r);

    // Reset mid left-hold: output drops at once, no LEFT afterward while held.
    clear_log();
    press(KEY_LEFT);
    step(1);
    chk("pre-reset valid", cmd_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async reset valid", cmd_valid, 0);
    chk("async reset cmd", cmd, int'(NONE));
    step(3);
    rst_n = 1'b1;
    clear_log();
    step(20);
    chk("post-reset quiet", log_cyc.size(), 0);
    key_down[KEY_LEFT] = 1'b0;
    step(2);

    // Right held 20 cycles.
    clear_log();
    press(KEY_RIGHT);
    step(19);
    key_down[KEY_RIGHT] = 1'b0;
    step(8);
`ifdef KEYCMD_AUTOREPEAT_EN
    exp_off = {2, 6, 8, 10, 12, 14, 16, 18, 20};
`else
    exp_off = {2};
`endif
    fill_cmd(RIGHT);
    expect_log("right hold", t0);

    // Unmapped scan code is ignored.
    clear_log();
    press(9'h01C);
    key_down[9'h01C] = 1'b0;
    step(6);
    chk("unmapped", log_cyc.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
